// File: rtl/cpa_resolver.sv
// cpa_resolver: resolves a redundant (sum, carry) pair into a 32-bit binary
// result with a CHUNK_W-bit adder slice, one slice per cycle, low chunk first.
// Optional build macro: CPA_ZERO_FLAG_EN adds the out_zero output.
//
// Handshake semantics (both ports): a transfer happens on a rising clk edge
// where valid && ready are both 1. in_ready is high only in IDLE. out_valid
// and out_product stay stable from the first cycle out_valid is high until
// the edge where out_ready is also high. out_ready is ignored while
// out_valid is low.
module cpa_resolver #(
  parameter int CHUNK_W = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_sum,
  input  logic [31:0] in_carry,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_product,
  output logic        busy,
`ifdef CPA_ZERO_FLAG_EN
  output logic        out_zero,
`endif
  output logic [1:0]  dbg_state
);

  localparam int N     = 32 / CHUNK_W;
  localparam int IDX_W = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADD  = 2'd1,
    HOLD = 2'd2
  } state_e;

  state_e             state_q;
  logic [IDX_W-1:0]   idx_q;
  logic               cin_q;
  logic [31:0]        sum_q;
  logic [31:0]        carry_q;
  logic [31:0]        prod_q;
  logic               valid_q;
`ifdef CPA_ZERO_FLAG_EN
  logic               nz_q;
  logic               zero_q;
`endif

  logic [4:0]         base_d;
  logic [CHUNK_W:0]   chunk_d;
  logic               last_d;

  // One slice of the carry-propagate add: selected operand chunks plus carry-in.
  always_comb begin
    base_d  = 5'(idx_q * CHUNK_W);
    chunk_d = {1'b0, sum_q[base_d +: CHUNK_W]}
            + {1'b0, carry_q[base_d +: CHUNK_W]}
            + {{CHUNK_W{1'b0}}, cin_q};
    last_d  = (idx_q == IDX_W'(N - 1));
  end

  // Control FSM plus datapath registers; carry-out of the top chunk is dropped.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      idx_q   <= '0;
      cin_q   <= 1'b0;
      sum_q   <= '0;
      carry_q <= '0;
      prod_q  <= '0;
      valid_q <= 1'b0;
`ifdef CPA_ZERO_FLAG_EN
      nz_q    <= 1'b0;
      zero_q  <= 1'b0;
`endif
    end else begin
      case (state_q)
        IDLE: begin
          if (in_valid) begin
            sum_q   <= in_sum;
            carry_q <= in_carry;
            idx_q   <= '0;
            cin_q   <= 1'b0;
`ifdef CPA_ZERO_FLAG_EN
            nz_q    <= 1'b0;
`endif
            state_q <= ADD;
          end
        end
        ADD: begin
          prod_q[base_d +: CHUNK_W] <= chunk_d[CHUNK_W-1:0];
          cin_q <= chunk_d[CHUNK_W];
          idx_q <= last_d ? '0 : idx_q + 1'b1;
`ifdef CPA_ZERO_FLAG_EN
          nz_q  <= nz_q | (|chunk_d[CHUNK_W-1:0]);
`endif
          if (last_d) begin
            state_q <= HOLD;
            valid_q <= 1'b1;
`ifdef CPA_ZERO_FLAG_EN
            zero_q  <= ~(nz_q | (|chunk_d[CHUNK_W-1:0]));
`endif
          end
        end
        HOLD: begin
          if (out_ready) begin
            valid_q <= 1'b0;
            state_q <= IDLE;
          end
        end
        default: begin
          state_q <= IDLE;
          valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready    = (state_q == IDLE);
  assign busy        = (state_q != IDLE);
  assign out_valid   = valid_q;
  assign out_product = prod_q;
  assign dbg_state   = state_q;
`ifdef CPA_ZERO_FLAG_EN
  assign out_zero    = zero_q;
`endif

endmodule

// File: tb/tb_cpa_resolver.sv
// tb_cpa_resolver: three resolver instances (CHUNK_W = 4, 8, 16) with a
// queue-based scoreboard per lane; expected results come from plain 32-bit
// addition of the issued operands.
module tb_cpa_resolver;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n;
  logic out_ready;
  logic        in_valid_v    [3];
  logic [31:0] in_sum_v      [3];
  logic [31:0] in_carry_v    [3];
  logic        in_ready_v    [3];
  logic        out_valid_v   [3];
  logic [31:0] out_product_v [3];
  logic        busy_v        [3];
  logic [1:0]  dbg_state_v   [3];
`ifdef CPA_ZERO_FLAG_EN
  logic        out_zero_v    [3];
`endif

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  logic [31:0] exp_q [3][$];
  int          hs_q  [3][$];

  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- DUTs and per-lane monitors ----------------
  for (genvar g = 0; g < 3; g++) begin : lane
    localparam int CW = 4 << g;
    localparam int NL = 32 / CW;

    cpa_resolver #(.CHUNK_W(CW)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .in_valid    (in_valid_v[g]),
      .in_ready    (in_ready_v[g]),
      .in_sum      (in_sum_v[g]),
      .in_carry    (in_carry_v[g]),
      .out_valid   (out_valid_v[g]),
      .out_ready   (out_ready),
      .out_product (out_product_v[g]),
      .busy        (busy_v[g]),
`ifdef CPA_ZERO_FLAG_EN
      .out_zero    (out_zero_v[g]),
`endif
      .dbg_state   (dbg_state_v[g])
    );

    logic        prev_valid = 1'b0;
    logic [31:0] prev_prod  = '0;

    always @(negedge clk) begin
      logic [31:0] e;
      if (out_valid_v[g]) begin
        checks++;
        if (!prev_valid) begin
          if (exp_q[g].size() == 0) begin
            failures++;
            $display("FAIL lane%0d unexpected_result got=%h required=no output", g, out_product_v[g]);
          end else if (cyc - hs_q[g][0] != NL) begin
            // visible in cycle N+1 after the handshake edge = N edges later
            failures++;
            $display("FAIL lane%0d latency got=%0d required=%0d edges", g, cyc - hs_q[g][0], NL);
          end
        end else if (out_product_v[g] !== prev_prod) begin
          failures++;
          $display("FAIL lane%0d hold_stable got=%h required=%h", g, out_product_v[g], prev_prod);
        end
        if (out_ready && exp_q[g].size() > 0) begin
          e = exp_q[g].pop_front();
          void'(hs_q[g].pop_front());
          checks++;
          if (out_product_v[g] !== e) begin
            failures++;
            $display("FAIL lane%0d product got=%h required=%h", g, out_product_v[g], e);
          end
`ifdef CPA_ZERO_FLAG_EN
          checks++;
          if (out_zero_v[g] !== (e == 32'd0)) begin
            failures++;
            $display("FAIL lane%0d out_zero got=%b required=%b", g, out_zero_v[g], (e == 32'd0));
          end
`endif
        end
      end
      prev_valid = out_valid_v[g];
      prev_prod  = out_product_v[g];
    end
  end

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check1(input string name, input logic act, input logic req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s got=%b required=%b", name, act, req);
    end
  endtask

  task automatic issue(input int ln, input logic [31:0] s, input logic [31:0] c, output int hs);
    int n = 0;
    in_valid_v[ln] = 1'b1;
    in_sum_v[ln]   = s;
    in_carry_v[ln] = c;
    while (!in_ready_v[ln] && n < 200) begin
      step();
      n++;
    end
    checks++;
    if (!in_ready_v[ln]) begin
      failures++;
      $display("FAIL lane%0d issue_timeout got=in_ready 0 required=in_ready 1", ln);
      in_valid_v[ln] = 1'b0;
      hs = -1;
      return;
    end
    exp_q[ln].push_back(s + c);
    step();
    hs = cyc;
    hs_q[ln].push_back(hs);
    in_valid_v[ln] = 1'b0;
    in_sum_v[ln]   = $urandom;
    in_carry_v[ln] = $urandom;
  endtask

  task automatic drain(input int ln, input bit rand_ready);
    int n = 0;
    while (exp_q[ln].size() > 0 && n < 500) begin
      if (rand_ready) out_ready = 1'($urandom_range(0, 1));
      step();
      n++;
    end
    out_ready = 1'b1;
    checks++;
    if (exp_q[ln].size() > 0) begin
      failures++;
      $display("FAIL lane%0d drain_timeout got=%0d pending required=0", ln, exp_q[ln].size());
      exp_q[ln].delete();
      hs_q[ln].delete();
    end
  endtask

  task automatic summary();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #500000;
    failures++;
    $display("FAIL watchdog got=timeout required=completion");
    summary();
    $finish;
  end

  // ---------------- stimulus ----------------
  initial begin
    int hs, prev_hs, nl, n;
    logic [31:0] s, c;
    for (int i = 0; i < 3; i++) begin
      in_valid_v[i] = 1'b0;
      in_sum_v[i]   = '0;
      in_carry_v[i] = '0;
    end
    out_ready = 1'b1;
    rst_n     = 1'b0;
    repeat (3) step();
    rst_n = 1'b1;

    // reset state on every lane
    for (int i = 0; i < 3; i++) begin
      check1($sformatf("lane%0d rst_in_ready", i), in_ready_v[i], 1'b1);
      check1($sformatf("lane%0d rst_out_valid", i), out_valid_v[i], 1'b0);
      check1($sformatf("lane%0d rst_busy", i), busy_v[i], 1'b0);
      check1($sformatf("lane%0d rst_product_zero", i), out_product_v[i] == 32'd0, 1'b1);
`ifdef CPA_ZERO_FLAG_EN
      check1($sformatf("lane%0d rst_out_zero", i), out_zero_v[i], 1'b0);
`endif
    end

    // ripple across chunk boundaries
    issue(1, 32'h0000FFFF, 32'h00000001, hs);
    check1("busy_in_add", busy_v[1], 1'b1);
    drain(1, 1'b0);

    // wrap with carry-out of bit 31 dropped
    issue(1, 32'hFFFFFFFF, 32'h00000001, hs);
    drain(1, 1'b0);

    // backpressure: result held for 10 cycles
    out_ready = 1'b0;
    issue(1, 32'hFFFFFFEA, 32'h00000002, hs);
    n = 0;
    while (!out_valid_v[1] && n < 50) begin
      step();
      n++;
    end
    check1("hold_valid_seen", out_valid_v[1], 1'b1);
    for (int k = 0; k < 10; k++) begin
      step();
      check1("hold_in_ready_low", in_ready_v[1], 1'b0);
      check1("hold_valid_high", out_valid_v[1], 1'b1);
    end
    out_ready = 1'b1;
    drain(1, 1'b0);
    check1("after_hold_in_ready", in_ready_v[1], 1'b1);

    // second in_valid pulse during ADD must not be captured
    issue(1, 32'h13572468, 32'h0ACE0000, hs);
    in_valid_v[1] = 1'b1;
    in_sum_v[1]   = 32'hDEADBEEF;
    in_carry_v[1] = 32'h11111111;
    check1("add_in_ready_low", in_ready_v[1], 1'b0);
    step();
    in_valid_v[1] = 1'b0;
    drain(1, 1'b0);
    repeat (12) step();
    check1("no_second_capture", out_valid_v[1], 1'b0);

    // reset during the second ADD cycle aborts the operation
    issue(1, 32'h12345678, 32'h9ABCDEF0, hs);
    step();
    rst_n = 1'b0;
    void'(exp_q[1].pop_back());
    void'(hs_q[1].pop_back());
    step();
    check1("abort_idle", dbg_state_v[1] == 2'd0, 1'b1);
    check1("abort_out_valid", out_valid_v[1], 1'b0);
    check1("abort_product_zero", out_product_v[1] == 32'd0, 1'b1);
    check1("abort_in_ready", in_ready_v[1], 1'b1);
    check1("abort_busy", busy_v[1], 1'b0);
    rst_n = 1'b1;
    repeat (15) step();
    check1("abort_no_stale", out_valid_v[1], 1'b0);

    // random operands with random backpressure on CHUNK_W=8
    for (int k = 0; k < 15; k++) begin
      s = $urandom;
      c = $urandom;
      if (k % 5 == 0) c = ~s + 32'd1;
      out_ready = 1'($urandom_range(0, 1));
      issue(1, s, c, hs);
      drain(1, 1'b1);
    end

    // back-to-back on CHUNK_W=4 and 16: interval N+2
    out_ready = 1'b1;
    for (int ln = 0; ln < 3; ln += 2) begin
      nl = 32 / (4 << ln);
      prev_hs = -1;
      for (int k = 0; k < 12; k++) begin
        s = $urandom;
        c = (k == 3) ? (32'd0 - s) : $urandom;
        issue(ln, s, c, hs);
        if (prev_hs >= 0) begin
          checks++;
          if (hs - prev_hs != nl + 2) begin
            failures++;
            $display("FAIL lane%0d interval got=%0d required=%0d", ln, hs - prev_hs, nl + 2);
          end
        end
        prev_hs = hs;
      end
      drain(ln, 1'b0);
    end

    repeat (5) step();
    summary();
    $finish;
  end

endmodule

// File: doc/cpa_resolver.md
CPA_RESOLVER -- requirements
Module: cpa_resolver

Interface
REQ-001 SHALL provide parameter CHUNK_W, default 8; the adder slice width per cycle; legal values are 4, 8 and 16.
REQ-002 SHALL provide port clk, input, 1 bit; the single clock, with all state updated on its rising edge.
REQ-003 SHALL provide port rst_n, input, 1 bit; reset is synchronous and active-low.
REQ-004 SHALL provide port in_valid, input, 1 bit; asserts that in_sum and in_carry are valid.
REQ-005 SHALL provide port in_ready, output, 1 bit; the block accepts an operand pair.
REQ-006 SHALL provide port in_sum, input, 32 bits; the redundant-form sum vector from the compression tree.
REQ-007 SHALL provide port in_carry, input, 32 bits; the redundant-form carry vector, already left-aligned (bit 0 is nominally 0 and is still added).
REQ-008 SHALL provide port out_valid, output, 1 bit; asserts that out_product is valid.
REQ-009 SHALL provide port out_ready, input, 1 bit; the downstream consumer accepts the result.
REQ-010 SHALL provide port out_product, output, 32 bits; the resolved binary result.
REQ-011 SHALL provide port busy, output, 1 bit; high in every state except IDLE.

Function
REQ-012 SHALL implement a three-state FSM with states IDLE, ADD and HOLD.
REQ-013 SHALL drive in_ready=1 only in IDLE; in_valid in ADD or HOLD is ignored and the operands are not captured.
REQ-014 SHALL, on in_valid&&in_ready, register both operands, clear the chunk index and the carry-in register, and go to ADD.
REQ-015 SHALL, in ADD, per cycle compute sum_chunk[idx]+carry_chunk[idx]+cin over CHUNK_W bits, write the result into out_product chunk idx, register the carry-out as the next cin, and increment idx.
REQ-016 SHALL spend exactly N=32/CHUNK_W cycles in ADD, then enter HOLD with out_valid=1.
REQ-017 SHALL have out_valid first visible N+1 cycles after the input-handshake edge; minimum initiation interval is N+2 cycles.
REQ-018 SHALL compute the result modulo 2^32 and discard the carry-out of bit 31 (two's-complement wrap).
REQ-019 SHALL, in HOLD, keep out_product and out_valid stable until out_valid&&out_ready, then return to IDLE on that edge.
REQ-020 SHALL ignore out_ready while out_valid=0.
REQ-021 SHALL be unaffected by operand input changes after capture.
REQ-022 SHALL leave out_product undefined during ADD; it is consumed only when out_valid=1.

Reset
REQ-023 SHALL, when rst_n=0 at a clock edge, force state IDLE, out_valid=0, out_product=0, idx=0, cin=0 and busy=0, with in_ready=1 after the edge.
REQ-024 SHALL, on reset in ADD or HOLD, abort the operation, discard any pending result, and produce no out_valid for it.

Configuration
REQ-025 SHALL, with macro CPA_ZERO_FLAG_EN defined, add output out_zero (1 bit), equal to 1 iff out_product==0, valid with out_valid, reset to 0, and built by accumulating a per-chunk nonzero OR during ADD.
REQ-026 SHALL, without CPA_ZERO_FLAG_EN, omit the out_zero port and all of its logic.

Verification
REQ-027 SHALL cover: CHUNK_W=8, sum=0x0000FFFF, carry=0x00000001 -> out_product=0x00010000 (ripple across chunks), out_valid in cycle 5 after the handshake.
REQ-028 SHALL cover: sum=0xFFFFFFFF, carry=0x00000001 -> out_product=0x00000000 with the carry-out dropped, and out_zero=1 when CPA_ZERO_FLAG_EN is defined.
REQ-029 SHALL cover: sum=0xFFFFFFEA, carry=0x00000002 -> 0xFFFFFFEC (-20); with out_ready held 0 for 10 cycles, the result stays stable, in_ready=0, and then one handshake occurs.
REQ-030 SHALL cover: a second in_valid pulse during ADD -> not captured, and the first result is unchanged.
REQ-031 SHALL cover: rst_n=0 in the second ADD cycle -> next cycle IDLE, out_valid=0, out_product=0, and no stale result later.
REQ-032 SHALL cover: back-to-back operations with out_ready=1 and CHUNK_W in {4, 16} -> results match a 32-bit reference add, with an interval of N+2 cycles.
